// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions for the instruction fetch stage: datapath
// width, decoder NOP encoding, reset fetch address and fetch FSM states.
package fetch_stage_pkg;

   localparam int XLEN = 32;

   localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0000;
   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef logic [1:0] fetch_state_t;

   localparam fetch_state_t ST_REQ  = 2'd0;
   localparam fetch_state_t ST_WAIT = 2'd1;
   localparam fetch_state_t ST_HOLD = 2'd2;

   // Instruction memory is word addressed; byte offset bits are forced to zero.
   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
      return {addr[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register. Flush beats everything (including stall) and
// leaves a NOP; a stall freezes the contents; an unstalled cycle with no new
// instruction leaves a bubble (valid cleared, data kept).
module if_id_reg
   import fetch_stage_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            stall_i,
   input  logic            load_i,
   input  logic            flush_i,
   input  logic [XLEN-1:0] instr_i,
   input  logic [XLEN-1:0] pc_plus4_i,
   output logic [XLEN-1:0] instr_o,
   output logic [XLEN-1:0] pc_plus4_o,
   output logic            valid_o
);

   logic [XLEN-1:0] instr_q;
   logic [XLEN-1:0] pc_plus4_q;
   logic            valid_q;

   // Pipeline register update: flush > stall hold > load > bubble.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr_q    <= NOP_INSTR;
         pc_plus4_q <= '0;
         valid_q    <= 1'b0;
      end else if (flush_i) begin
         instr_q <= NOP_INSTR;
         valid_q <= 1'b0;
      end else if (!stall_i) begin
         if (load_i) begin
            instr_q    <= instr_i;
            pc_plus4_q <= pc_plus4_i;
            valid_q    <= 1'b1;
         end else begin
            valid_q <= 1'b0;
         end
      end
   end

   assign instr_o    = instr_q;
   assign pc_plus4_o = pc_plus4_q;
   assign valid_o    = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, fetch FSM and instruction memory handshake.
// Optional build macro IF_DELAY_SLOT_EN: redirects take effect after one
// delay-slot instruction instead of flushing.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_REQ  | request asserted at pc, waiting for imem_gnt
// ST_WAIT | request accepted, waiting for imem_rvalid
// ST_HOLD | response buffered because IF/ID was stalled
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            stall,
   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_gnt,
   input  logic            imem_rvalid,
   input  logic [XLEN-1:0] imem_rdata,
   output logic [XLEN-1:0] Instruction_id,
   output logic [XLEN-1:0] PC_plus4_id,
   output logic            valid_id
);

   fetch_state_t    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] buf_q, buf_d;
   logic            live_q;
   logic            load;
   logic            flush;
   logic [XLEN-1:0] load_instr;
   logic [XLEN-1:0] pc_plus4;
   logic [XLEN-1:0] redir_tgt;
   logic            req_gnt;

`ifdef IF_DELAY_SLOT_EN
   logic            pend_q, pend_d;
   logic [XLEN-1:0] pend_pc_q, pend_pc_d;
   logic [XLEN-1:0] next_pc;
`else
   logic            drop_q, drop_d;
`endif

   assign pc_plus4  = pc_q + 32'd4;
   assign redir_tgt = word_align(redirect_pc);

   // live_q keeps the request low while in reset and for the partial cycle
   // after release, so nothing seen before the first clean edge is acted on.
   assign imem_req  = live_q && (state_q == ST_REQ);
   assign imem_addr = word_align(pc_q);
   assign req_gnt   = imem_req && imem_gnt;

`ifdef IF_DELAY_SLOT_EN
   // A redirect arriving in the completion cycle itself targets the very next
   // fetch; otherwise a latched target wins over sequential pc+4.
   assign next_pc = redirect ? redir_tgt : (pend_q ? pend_pc_q : pc_plus4);
`endif

   // Fetch FSM next-state, PC sequencing and IF/ID load/flush control.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      buf_d      = buf_q;
      load       = 1'b0;
      flush      = 1'b0;
      load_instr = imem_rdata;
`ifdef IF_DELAY_SLOT_EN
      pend_d     = pend_q;
      pend_pc_d  = pend_pc_q;
      if (redirect) begin
         pend_d    = 1'b1;
         pend_pc_d = redir_tgt;
      end
      case (state_q)
         ST_REQ: begin
            if (req_gnt) state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (imem_rvalid) begin
               if (stall) begin
                  buf_d   = imem_rdata;
                  state_d = ST_HOLD;
               end else begin
                  load    = 1'b1;
                  pc_d    = next_pc;
                  pend_d  = 1'b0;
                  state_d = ST_REQ;
               end
            end
         end
         ST_HOLD: begin
            if (!stall) begin
               load       = 1'b1;
               load_instr = buf_q;
               pc_d       = next_pc;
               pend_d     = 1'b0;
               state_d    = ST_REQ;
            end
         end
         default: state_d = ST_REQ;
      endcase
`else
      drop_d = drop_q;
      case (state_q)
         ST_REQ: begin
            if (redirect) begin
               pc_d  = redir_tgt;
               flush = 1'b1;
               if (req_gnt) begin
                  drop_d  = 1'b1;
                  state_d = ST_WAIT;
               end
            end else if (req_gnt) begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (redirect) begin
               pc_d  = redir_tgt;
               flush = 1'b1;
               if (imem_rvalid) begin
                  drop_d  = 1'b0;
                  state_d = ST_REQ;
               end else begin
                  drop_d = 1'b1;
               end
            end else if (imem_rvalid) begin
               if (drop_q) begin
                  drop_d  = 1'b0;
                  state_d = ST_REQ;
               end else if (stall) begin
                  buf_d   = imem_rdata;
                  state_d = ST_HOLD;
               end else begin
                  load    = 1'b1;
                  pc_d    = pc_plus4;
                  state_d = ST_REQ;
               end
            end
         end
         ST_HOLD: begin
            if (redirect) begin
               pc_d    = redir_tgt;
               flush   = 1'b1;
               buf_d   = NOP_INSTR;
               state_d = ST_REQ;
            end else if (!stall) begin
               load       = 1'b1;
               load_instr = buf_q;
               pc_d       = pc_plus4;
               state_d    = ST_REQ;
            end
         end
         default: state_d = ST_REQ;
      endcase
`endif
   end

   // Fetch state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_REQ;
         pc_q    <= word_align(RESET_PC);
         buf_q   <= NOP_INSTR;
         live_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         buf_q   <= buf_d;
         live_q  <= 1'b1;
      end
   end

`ifdef IF_DELAY_SLOT_EN
   // Pending redirect target, applied when the delay slot completes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_q    <= 1'b0;
         pend_pc_q <= '0;
      end else begin
         pend_q    <= pend_d;
         pend_pc_q <= pend_pc_d;
      end
   end
`else
   // Drop flag: the outstanding response belongs to a redirected-away path.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) drop_q <= 1'b0;
      else        drop_q <= drop_d;
   end
`endif

   if_id_reg u_if_id (
      .clk        (clk),
      .rst_n      (rst_n),
      .stall_i    (stall),
      .load_i     (load),
      .flush_i    (flush),
      .instr_i    (load_instr),
      .pc_plus4_i (pc_plus4),
      .instr_o    (Instruction_id),
      .pc_plus4_o (PC_plus4_id),
      .valid_o    (valid_id)
   );

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 stall  in  1  hazard unit: hold IF/ID register contents.
REQ-005 redirect  in  1  taken branch, J or JR resolved in ID.
REQ-006 redirect_pc  in  32  redirect target address.
REQ-007 imem_req  out  1  instruction fetch request.
REQ-008 imem_addr  out  32  fetch address, word-aligned.
REQ-009 imem_gnt  in  1  request accepted this cycle.
REQ-010 imem_rvalid  in  1  read data valid; at most one outstanding request.
REQ-011 imem_rdata  in  32  fetched instruction.
REQ-012 Instruction_id  out  32  IF/ID instruction, consumed by the decoder.
REQ-013 PC_plus4_id  out  32  IF/ID address of the instruction plus 4.
REQ-014 valid_id  out  1  IF/ID holds a real instruction.

Function
REQ-015 The FSM SHALL have states REQ, WAIT and HOLD.
- REQ: imem_req=1 and imem_addr=pc; imem_gnt moves the FSM to WAIT.
- WAIT: imem_req=0.
- HOLD: buffered instruction waiting for stall to drop.
REQ-016 WAIT with imem_rvalid and stall=0 SHALL write imem_rdata and pc+4 into IF/ID, set valid_id=1, set pc<=pc+4 and go to REQ.
REQ-017 WAIT with imem_rvalid and stall=1 SHALL capture imem_rdata in a one-entry buffer and go to HOLD.
REQ-018 HOLD with stall=0 SHALL load the buffer into IF/ID, advance pc by 4 and go to REQ.
REQ-019 While stall=1 the IF/ID outputs SHALL hold, and requests in REQ SHALL still issue.
REQ-020 Fetch latency SHALL be one cycle from imem_rvalid to the IF/ID update, with no combinational path from imem_rdata to the outputs.
REQ-021 pc+4 SHALL wrap modulo 2^32; imem_addr[1:0] SHALL always be 2'b00, and redirect_pc[1:0] SHALL be ignored.
REQ-022 Redirect SHALL have priority over stall and over normal sequencing when both are asserted in the same cycle.
REQ-023 Redirect without delay slot:
- pc<=redirect_pc.
- IF/ID SHALL be flushed: Instruction_id=32'h0 (decoder NOP), valid_id=0.
- In HOLD, the buffer SHALL be discarded and the FSM SHALL go to REQ.
- In WAIT, a drop flag SHALL be set, and the pending response SHALL be discarded on arrival, including when it arrives in the redirect cycle itself.
REQ-024 The flush SHALL occur even if stall=1.
REQ-025 A redirect in REQ in the same cycle as imem_gnt SHALL still drop that request's response.
REQ-026 A second redirect before the first completes SHALL overwrite the target; the last redirect wins.

Reset
REQ-027 While rst_n=0 the block SHALL hold:
- pc=RESET_PC, state=REQ, drop flag=0, buffer empty.
- Instruction_id=32'h0, PC_plus4_id=32'h0, valid_id=0, imem_req=0.
REQ-028 Assertion of rst_n mid-transaction SHALL abandon any outstanding request, and an imem_rvalid in the first cycle after release SHALL be ignored.
REQ-029 imem_req SHALL rise in the first cycle after rst_n deasserts.

Configuration
REQ-030 The macro IF_DELAY_SLOT_EN SHALL select delay-slot behaviour.
- Defined: redirect SHALL latch redirect_pc into a pending-target register and SHALL NOT flush IF/ID or drop the in-flight, buffered or next-issued sequential fetch (the delay slot).
- Defined: on completion of the delay slot, pc SHALL load the pending target instead of pc+4.
- Undefined: REQ-023 applies, and no pending-target register SHALL exist.

Structure
REQ-031 The shared pipeline package SHALL hold:
- the NOP encoding 32'h0;
- the FSM state typedef;
- the RESET_PC default;
- the width constant 32.
REQ-032 The IF/ID register with stall/flush SHALL be the sub-module if_id_reg; the PC and FSM logic SHALL stay in fetch_stage.

Verification
REQ-033 The bench SHALL cover these scenarios:
- Reset release, gnt=1 every cycle, rvalid one cycle after gnt -> imem_addr 0,4,8 and PC_plus4_id 4,8,C with valid_id=1.
- stall=1 for 3 cycles while rvalid arrives with 32'h2008_0005 -> IF/ID unchanged during stall; that instruction appears one cycle after stall drops; no address skipped.
- redirect to 32'h0000_0040 while in WAIT (macro off) -> late response discarded; Instruction_id=0, valid_id=0; next imem_addr=32'h40.
- redirect and stall asserted together in HOLD -> buffer dropped, IF/ID flushed, next imem_addr=redirect_pc.
- Macro on, redirect to 32'h100 with the fetch of 32'h14 in flight -> 32'h14 delivered with valid_id=1; next imem_addr=32'h100.
- rst_n pulsed low while in WAIT with rvalid arriving after release -> response ignored; imem_addr=RESET_PC.
